// File: rtl/instruction_fetch_pkg.sv
// Shared constants and types for the LAPIDO instruction-fetch stage.
package instruction_fetch_pkg;

  // Encoding of a bubble in the decode stage (opcode/funct all zero).
  localparam logic [31:0] INSTR_NOP = 32'h0000_0000;

  // Default first fetch address after reset.
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Front-end sequencing states.
  typedef enum logic [1:0] {
    IF_IDLE    = 2'd0,  // single cycle after reset release
    IF_FETCH   = 2'd1,  // request outstanding at fetch_addr
    IF_HOLD    = 2'd2,  // fetched word parked while decode is stalled
    IF_DISCARD = 2'd3   // wrong-path request still completing
  } if_state_e;

endpackage : instruction_fetch_pkg

// File: rtl/if_id_register.sv
// IF/ID pipeline register: flush beats load, load beats hold.
module if_id_register
  import instruction_fetch_pkg::*;
#(
  parameter int unsigned PC_WIDTH    = 32,
  parameter int unsigned INSTR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load_i,
  input  logic                   flush_i,
  input  logic [INSTR_WIDTH-1:0] instr_i,
  input  logic [PC_WIDTH-1:0]    pc_plus1_i,
  output logic                   valid_o,
  output logic [INSTR_WIDTH-1:0] instr_o,
  output logic [PC_WIDTH-1:0]    pc_plus1_o
);

  logic                   valid_q, valid_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic [PC_WIDTH-1:0]    pc_plus1_q, pc_plus1_d;

  // Select the next register contents from the flush/load controls.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    valid_d    = valid_q;
    instr_d    = instr_q;
    pc_plus1_d = pc_plus1_q;
    if (flush_i) begin
      // A flush only invalidates; pc_plus1 is meaningless once valid is low.
      valid_d = 1'b0;
      instr_d = INSTR_WIDTH'(INSTR_NOP);
    end else if (load_i) begin
      valid_d    = 1'b1;
      instr_d    = instr_i;
      pc_plus1_d = pc_plus1_i;
    end
  end

  // State register with asynchronous reset to an empty bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      instr_q    <= INSTR_WIDTH'(INSTR_NOP);
      pc_plus1_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      pc_plus1_q <= pc_plus1_d;
    end
  end

  assign valid_o    = valid_q;
  assign instr_o    = instr_q;
  assign pc_plus1_o = pc_plus1_q;

endmodule : if_id_register

// File: rtl/instruction_fetch.sv
// Instruction-fetch stage: PC, imem request/ack handshake, stall hold buffer,
// redirect handling with wrong-path discard, and the IF/ID register.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int unsigned          PC_WIDTH    = 32,
  parameter int unsigned          INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]  RESET_PC    = PC_WIDTH'(RESET_PC_DEFAULT)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   stall,
  input  logic                   redirect,
  input  logic [PC_WIDTH-1:0]    redirect_pc,
  output logic                   imem_req,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic                   imem_ack,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic                   if_id_valid,
  output logic [INSTR_WIDTH-1:0] if_id_instr,
  output logic [PC_WIDTH-1:0]    if_id_pc_plus1
);

  if_state_e state_q, state_d;

  // pc is the architectural next-fetch address; fetch_addr is the address on
  // the bus. They differ only while a stale request drains in IF_DISCARD.
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [PC_WIDTH-1:0]    fetch_addr_q, fetch_addr_d;

  // Hold buffer. Its occupancy is implied by state IF_HOLD, so no valid bit.
  logic [INSTR_WIDTH-1:0] hold_instr_q, hold_instr_d;
  logic [PC_WIDTH-1:0]    hold_pc_plus1_q, hold_pc_plus1_d;

  logic [PC_WIDTH-1:0]    fetch_plus1;
  logic                   ifid_load;
  logic                   ifid_flush;
  logic [INSTR_WIDTH-1:0] ifid_instr_in;
  logic [PC_WIDTH-1:0]    ifid_pc_plus1_in;

  // Wraps modulo 2^PC_WIDTH.
  assign fetch_plus1 = fetch_addr_q + PC_WIDTH'(1);

  // Next-state, PC, hold buffer and IF/ID control; redirect wins over stall and ack.
  always_comb begin
    state_d          = state_q;
    pc_d             = pc_q;
    fetch_addr_d     = fetch_addr_q;
    hold_instr_d     = hold_instr_q;
    hold_pc_plus1_d  = hold_pc_plus1_q;
    imem_req         = 1'b0;
    ifid_load        = 1'b0;
    ifid_flush       = 1'b0;
    ifid_instr_in    = imem_rdata;
    ifid_pc_plus1_in = fetch_plus1;

    unique case (state_q)
      IF_IDLE: begin
        state_d = IF_FETCH;
        if (redirect) begin
          ifid_flush   = 1'b1;
          pc_d         = redirect_pc;
          fetch_addr_d = redirect_pc;
        end
      end

      IF_FETCH: begin
        imem_req = 1'b1;
        if (redirect) begin
          ifid_flush = 1'b1;
          pc_d       = redirect_pc;
          if (imem_ack) begin
            // Wrong-path word arrived with the redirect: drop it, refetch now.
            fetch_addr_d = redirect_pc;
          end else begin
            // The bus request cannot be withdrawn, so drain it first.
            state_d = IF_DISCARD;
          end
        end else if (imem_ack) begin
          pc_d         = fetch_plus1;
          fetch_addr_d = fetch_plus1;
          if (stall) begin
            hold_instr_d    = imem_rdata;
            hold_pc_plus1_d = fetch_plus1;
            state_d         = IF_HOLD;
          end else begin
            ifid_load = 1'b1;
          end
        end else if (!stall) begin
          // Decode consumed the previous word and nothing new arrived.
          ifid_flush = 1'b1;
        end
      end

      IF_HOLD: begin
        if (redirect) begin
          ifid_flush   = 1'b1;
          pc_d         = redirect_pc;
          fetch_addr_d = redirect_pc;
          state_d      = IF_FETCH;
        end else if (!stall) begin
          ifid_load        = 1'b1;
          ifid_instr_in    = hold_instr_q;
          ifid_pc_plus1_in = hold_pc_plus1_q;
          fetch_addr_d     = pc_q;
          state_d          = IF_FETCH;
        end
      end

      IF_DISCARD: begin
        imem_req = 1'b1;
        if (redirect) begin
          // A newer redirect only retargets the PC; the drain continues.
          ifid_flush = 1'b1;
          pc_d       = redirect_pc;
        end else begin
          if (imem_ack) begin
            fetch_addr_d = pc_q;
            state_d      = IF_FETCH;
          end
          if (!stall) begin
            ifid_flush = 1'b1;
          end
        end
      end

      default: begin
        state_d = IF_IDLE;
      end
    endcase
  end

  // Front-end state registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IF_IDLE;
      pc_q            <= RESET_PC;
      fetch_addr_q    <= RESET_PC;
      hold_instr_q    <= INSTR_WIDTH'(INSTR_NOP);
      hold_pc_plus1_q <= '0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      fetch_addr_q    <= fetch_addr_d;
      hold_instr_q    <= hold_instr_d;
      hold_pc_plus1_q <= hold_pc_plus1_d;
    end
  end

  assign imem_addr = fetch_addr_q;

  if_id_register #(
    .PC_WIDTH    (PC_WIDTH),
    .INSTR_WIDTH (INSTR_WIDTH)
  ) u_if_id (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (ifid_load),
    .flush_i    (ifid_flush),
    .instr_i    (ifid_instr_in),
    .pc_plus1_i (ifid_pc_plus1_in),
    .valid_o    (if_id_valid),
    .instr_o    (if_id_instr),
    .pc_plus1_o (if_id_pc_plus1)
  );

endmodule : instruction_fetch

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a data=address memory model of
// configurable latency, plus a second instance exercising PC wrap-around.
module tb_instruction_fetch;
  import instruction_fetch_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc_plus1;

  // Wrap-around instance signals.
  logic        rst_n2;
  logic        imem_req2;
  logic [31:0] imem_addr2;
  logic        imem_ack2;
  logic [31:0] imem_rdata2;
  logic        if_id_valid2;
  logic [31:0] if_id_instr2;
  logic [31:0] if_id_pc_plus1_2;

  int unsigned pass_cnt;
  int unsigned check_cnt;

  // Memory model: ack once the request has waited `latency` cycles.
  int unsigned latency;
  logic        mem_hold;
  int unsigned wait_cnt;

  assign imem_ack   = imem_req && !mem_hold && (wait_cnt >= latency);
  assign imem_rdata = imem_addr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) wait_cnt <= 0;
    else if (imem_req && !imem_ack) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  assign imem_ack2   = imem_req2;
  assign imem_rdata2 = imem_addr2;

  instruction_fetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .if_id_valid    (if_id_valid),
    .if_id_instr    (if_id_instr),
    .if_id_pc_plus1 (if_id_pc_plus1)
  );

  instruction_fetch #(.RESET_PC(32'hFFFF_FFFF)) dut_wrap (
    .clk            (clk),
    .rst_n          (rst_n2),
    .stall          (1'b0),
    .redirect       (1'b0),
    .redirect_pc    (32'h0),
    .imem_req       (imem_req2),
    .imem_addr      (imem_addr2),
    .imem_ack       (imem_ack2),
    .imem_rdata     (imem_rdata2),
    .if_id_valid    (if_id_valid2),
    .if_id_instr    (if_id_instr2),
    .if_id_pc_plus1 (if_id_pc_plus1_2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    check_cnt++;
    if ({imem_req, imem_addr} !== {1'b0, 32'h0})
      $display("FAIL reset_bus: got req=%0b addr=%h want req=0 addr=0", imem_req, imem_addr);
    else pass_cnt++;
    check_cnt++;
    if ({if_id_valid, if_id_instr, if_id_pc_plus1} !== {1'b0, 32'h0, 32'h0})
      $display("FAIL reset_ifid: got v=%0b i=%h p=%h want 0/0/0", if_id_valid, if_id_instr, if_id_pc_plus1);
    else pass_cnt++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    // Cycle 0 after release is IDLE: no request yet.
    check_cnt++;
    if (imem_req !== 1'b0) $display("FAIL idle_req: got %0b want 0", imem_req);
    else pass_cnt++;
  endtask

  task automatic test_stream();
    tick();
    check_cnt++;
    if ({imem_req, imem_addr, if_id_valid} !== {1'b1, 32'h0, 1'b0})
      $display("FAIL first_req: got req=%0b addr=%h v=%0b want 1/0/0", imem_req, imem_addr, if_id_valid);
    else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_cnt++;
      if ({if_id_valid, if_id_instr, if_id_pc_plus1} !== {1'b1, 32'(i), 32'(i + 1)})
        $display("FAIL stream_%0d: got v=%0b i=%h p=%h want 1/%h/%h", i, if_id_valid,
                 if_id_instr, if_id_pc_plus1, i, i + 1);
      else pass_cnt++;
    end
  endtask

  task automatic test_stall();
    // Ack for address 5 is present now; stall for two cycles.
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check_cnt++;
      if ({dut.state_q, imem_req, if_id_valid, if_id_instr} !== {IF_HOLD, 1'b0, 1'b1, 32'h4})
        $display("FAIL stall_hold_%0d: got st=%0d req=%0b v=%0b i=%h want HOLD/0/1/4", i,
                 dut.state_q, imem_req, if_id_valid, if_id_instr);
      else pass_cnt++;
    end
    stall = 1'b0;
    tick();
    check_cnt++;
    if ({if_id_valid, if_id_instr, if_id_pc_plus1} !== {1'b1, 32'h5, 32'h6})
      $display("FAIL stall_release: got v=%0b i=%h p=%h want 1/5/6", if_id_valid, if_id_instr, if_id_pc_plus1);
    else pass_cnt++;
    check_cnt++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h6})
      $display("FAIL stall_refetch: got req=%0b addr=%h want 1/6", imem_req, imem_addr);
    else pass_cnt++;
    tick();
    check_cnt++;
    if ({if_id_valid, if_id_instr} !== {1'b1, 32'h6})
      $display("FAIL stall_no_dup: got v=%0b i=%h want 1/6", if_id_valid, if_id_instr);
    else pass_cnt++;
  endtask

  task automatic test_slow_memory();
    latency = 2;
    for (int k = 7; k < 9; k++) begin
      for (int w = 0; w < 2; w++) begin
        tick();
        check_cnt++;
        if ({imem_req, imem_addr, if_id_valid} !== {1'b1, 32'(k), 1'b0})
          $display("FAIL slow_wait_%0d_%0d: got req=%0b addr=%h v=%0b want 1/%h/0", k, w,
                   imem_req, imem_addr, if_id_valid, k);
        else pass_cnt++;
      end
      tick();
      check_cnt++;
      if ({if_id_valid, if_id_instr, if_id_pc_plus1} !== {1'b1, 32'(k), 32'(k + 1)})
        $display("FAIL slow_load_%0d: got v=%0b i=%h p=%h want 1/%h/%h", k, if_id_valid,
                 if_id_instr, if_id_pc_plus1, k, k + 1);
      else pass_cnt++;
    end
  endtask

  task automatic test_redirect_discard();
    // Request to 9 is outstanding with no ack this cycle.
    redirect    = 1'b1;
    redirect_pc = 32'h40;
    tick();
    redirect = 1'b0;
    check_cnt++;
    if ({dut.state_q, imem_req, imem_addr, if_id_valid} !== {IF_DISCARD, 1'b1, 32'h9, 1'b0})
      $display("FAIL redir_discard: got st=%0d req=%0b addr=%h v=%0b want DISCARD/1/9/0",
               dut.state_q, imem_req, imem_addr, if_id_valid);
    else pass_cnt++;
    tick();  // stale ack present in this cycle
    tick();
    check_cnt++;
    if ({imem_req, imem_addr, if_id_valid} !== {1'b1, 32'h40, 1'b0})
      $display("FAIL redir_target: got req=%0b addr=%h v=%0b want 1/40/0", imem_req, imem_addr, if_id_valid);
    else pass_cnt++;
    tick();
    tick();
    check_cnt++;
    if (if_id_valid !== 1'b0) $display("FAIL redir_wait: got v=%0b want 0", if_id_valid);
    else pass_cnt++;
    tick();
    check_cnt++;
    if ({if_id_valid, if_id_instr, if_id_pc_plus1} !== {1'b1, 32'h40, 32'h41})
      $display("FAIL redir_decode: got v=%0b i=%h p=%h want 1/40/41", if_id_valid, if_id_instr, if_id_pc_plus1);
    else pass_cnt++;
  endtask

  task automatic test_redirect_stall_ack();
    latency     = 0;  // ack for 0x41 is present now
    stall       = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h80;
    tick();
    stall    = 1'b0;
    redirect = 1'b0;
    check_cnt++;
    if ({dut.state_q, imem_req, imem_addr, if_id_valid, if_id_instr} !==
        {IF_FETCH, 1'b1, 32'h80, 1'b0, 32'h0})
      $display("FAIL rsa_flush: got st=%0d req=%0b addr=%h v=%0b i=%h want FETCH/1/80/0/0",
               dut.state_q, imem_req, imem_addr, if_id_valid, if_id_instr);
    else pass_cnt++;
    tick();
    check_cnt++;
    if ({if_id_valid, if_id_instr, if_id_pc_plus1} !== {1'b1, 32'h80, 32'h81})
      $display("FAIL rsa_decode: got v=%0b i=%h p=%h want 1/80/81", if_id_valid, if_id_instr, if_id_pc_plus1);
    else pass_cnt++;
  endtask

  task automatic test_redirect_hold();
    stall = 1'b1;  // ack for 0x81 parks in the hold buffer
    tick();
    redirect    = 1'b1;
    redirect_pc = 32'h20;
    tick();
    redirect = 1'b0;
    stall    = 1'b0;
    check_cnt++;
    if ({dut.state_q, imem_addr, if_id_valid} !== {IF_FETCH, 32'h20, 1'b0})
      $display("FAIL rh_flush: got st=%0d addr=%h v=%0b want FETCH/20/0", dut.state_q, imem_addr, if_id_valid);
    else pass_cnt++;
    tick();
    check_cnt++;
    if ({if_id_valid, if_id_instr} !== {1'b1, 32'h20})
      $display("FAIL rh_decode: got v=%0b i=%h want 1/20", if_id_valid, if_id_instr);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_wait();
    mem_hold = 1'b1;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_cnt++;
    if ({imem_req, imem_addr, if_id_valid, if_id_instr, if_id_pc_plus1} !==
        {1'b0, 32'h0, 1'b0, 32'h0, 32'h0})
      $display("FAIL async_reset: got req=%0b addr=%h v=%0b i=%h p=%h want all 0",
               imem_req, imem_addr, if_id_valid, if_id_instr, if_id_pc_plus1);
    else pass_cnt++;
    mem_hold = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    check_cnt++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h0})
      $display("FAIL reset_restart: got req=%0b addr=%h want 1/0", imem_req, imem_addr);
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    @(posedge clk);
    #1;
    rst_n2 = 1'b1;
    tick();
    check_cnt++;
    if ({imem_req2, imem_addr2} !== {1'b1, 32'hFFFF_FFFF})
      $display("FAIL wrap_req: got req=%0b addr=%h want 1/ffffffff", imem_req2, imem_addr2);
    else pass_cnt++;
    tick();
    check_cnt++;
    if ({if_id_valid2, if_id_instr2, if_id_pc_plus1_2, imem_addr2} !==
        {1'b1, 32'hFFFF_FFFF, 32'h0, 32'h0})
      $display("FAIL wrap_plus1: got v=%0b i=%h p=%h addr=%h want 1/ffffffff/0/0",
               if_id_valid2, if_id_instr2, if_id_pc_plus1_2, imem_addr2);
    else pass_cnt++;
    tick();
    check_cnt++;
    if ({if_id_instr2, if_id_pc_plus1_2} !== {32'h0, 32'h1})
      $display("FAIL wrap_next: got i=%h p=%h want 0/1", if_id_instr2, if_id_pc_plus1_2);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt    = 0;
    check_cnt   = 0;
    rst_n       = 1'b0;
    rst_n2      = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    latency     = 0;
    mem_hold    = 1'b0;

    test_reset();
    test_stream();
    test_stall();
    test_slow_memory();
    test_redirect_discard();
    test_redirect_stall_ack();
    test_redirect_hold();
    test_reset_mid_wait();
    test_wrap();

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule : tb_instruction_fetch
